// File: rtl/regbank_op_sequencer.sv
// regbank_op_sequencer
// Command sequencer in front of a bank of NREG 16-bit load/inc/dec/clear
// registers. Two requesters compete for one command slot. Multi-step INC/DEC
// commands are expanded into single-step register enables, and the sequencer
// pulses Done with the requester id when the command finishes.
//
// Build option:
//   REGBANK_SEQ_ROUND_ROBIN_EN  defined   -> round-robin between requesters
//                               undefined -> requester 0 has fixed priority
//
// Ports:
//   clock_i, reset_i        clock, synchronous active-high reset
//   reqN_valid_i            requester N command valid
//   reqN_ready_c_o          requester N granted this cycle (combinational from valid)
//   reqN_sel_i              target register index (SELW bits)
//   reqN_op_i               00 DEC, 01 INC, 10 LOAD, 11 CLEAR
//   reqN_count_i            INC/DEC step count (CNTW bits)
//   reqN_data_i             LOAD value
//   reg_e_c_o               one-hot register enable, forced low while in reset
//   reg_fun_sel_o           function select to all registers
//   reg_i_o                 data to all registers
//   busy_o                  command in progress
//   done_o, done_id_o       one-cycle completion pulse and requester id
//
// Parameters must satisfy 2**SELW >= NREG.

module regbank_op_sequencer #(
    parameter  int unsigned NREG  = 4,
    parameter  int unsigned SELW  = 2,
    parameter  int unsigned CNTW  = 4,
    localparam int unsigned DATAW = 16,
    localparam int unsigned OPW   = 2
) (
    input  logic             clock_i,
    input  logic             reset_i,

    input  logic             req0_valid_i,
    output logic             req0_ready_c_o,
    input  logic [SELW-1:0]  req0_sel_i,
    input  logic [OPW-1:0]   req0_op_i,
    input  logic [CNTW-1:0]  req0_count_i,
    input  logic [DATAW-1:0] req0_data_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_c_o,
    input  logic [SELW-1:0]  req1_sel_i,
    input  logic [OPW-1:0]   req1_op_i,
    input  logic [CNTW-1:0]  req1_count_i,
    input  logic [DATAW-1:0] req1_data_i,

    output logic [NREG-1:0]  reg_e_c_o,
    output logic [OPW-1:0]   reg_fun_sel_o,
    output logic [DATAW-1:0] reg_i_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             done_id_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t            state_q,   state_d;

    // latched command
    logic [SELW-1:0]   sel_q,     sel_d;
    logic [OPW-1:0]    op_q,      op_d;
    logic [DATAW-1:0]  data_q,    data_d;
    logic [CNTW-1:0]   rem_q,     rem_d;
    logic              id_q,      id_d;

    // registered outputs
    logic [NREG-1:0]   reg_e_q,   reg_e_d;
    logic [OPW-1:0]    fun_sel_q, fun_sel_d;
    logic [DATAW-1:0]  reg_i_q,   reg_i_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              done_id_q, done_id_d;

`ifdef REGBANK_SEQ_ROUND_ROBIN_EN
    // 0: requester 0 favoured on contention, 1: requester 1 favoured
    logic              rr_q,      rr_d;
`endif

    // arbitration results
    logic              gnt0;
    logic              gnt1;
    logic              hs;
    logic [SELW-1:0]   win_sel;
    logic [OPW-1:0]    win_op;
    logic [CNTW-1:0]   win_cnt;
    logic [DATAW-1:0]  win_data;

    // Grant logic: only in IDLE and never while reset is applied
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset_i && (state_q == ST_IDLE)) begin
`ifdef REGBANK_SEQ_ROUND_ROBIN_EN
            if (req0_valid_i && req1_valid_i) begin
                gnt0 = ~rr_q;
                gnt1 = rr_q;
            end else begin
                gnt0 = req0_valid_i;
                gnt1 = req1_valid_i;
            end
`else
            gnt0 = req0_valid_i;
            gnt1 = req1_valid_i & ~req0_valid_i;
`endif
        end
    end

    assign hs             = gnt0 | gnt1;
    assign req0_ready_c_o = gnt0;
    assign req1_ready_c_o = gnt1;

    // Winning command payload
    assign win_sel  = gnt1 ? req1_sel_i   : req0_sel_i;
    assign win_op   = gnt1 ? req1_op_i    : req0_op_i;
    assign win_cnt  = gnt1 ? req1_count_i : req0_count_i;
    assign win_data = gnt1 ? req1_data_i  : req0_data_i;

    // Next-state and registered-output decode
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        op_d      = op_q;
        data_d    = data_q;
        rem_d     = rem_q;
        id_d      = id_q;
        fun_sel_d = fun_sel_q;
        reg_i_d   = reg_i_q;
        reg_e_d   = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
`ifdef REGBANK_SEQ_ROUND_ROBIN_EN
        rr_d      = rr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    sel_d  = win_sel;
                    op_d   = win_op;
                    data_d = win_data;
                    rem_d  = win_cnt;
                    id_d   = gnt1;
`ifdef REGBANK_SEQ_ROUND_ROBIN_EN
                    rr_d   = ~gnt1;
`endif
                    // op[1] set means LOAD/CLEAR; a zero-step INC/DEC is a no-op
                    if (win_op[1] || (win_cnt != '0)) begin
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_EXEC: begin
                // LOAD/CLEAR take one step; INC/DEC leave on their last step
                if (op_q[1] || (rem_q == CNTW'(1))) begin
                    state_d = ST_DONE;
                end else begin
                    rem_d = rem_q - CNTW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the state being entered
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        if (state_d == ST_DONE) begin
            done_id_d = id_d;
        end
        if (state_d == ST_EXEC) begin
            fun_sel_d = op_d;
            reg_i_d   = data_d;
            // out-of-range select matches no bit and leaves all enables low
            for (int unsigned i = 0; i < NREG; i++) begin
                reg_e_d[i] = (sel_d == SELW'(i));
            end
        end
    end

    // State and output registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            op_q      <= '0;
            data_q    <= '0;
            rem_q     <= '0;
            id_q      <= 1'b0;
            reg_e_q   <= '0;
            fun_sel_q <= '0;
            reg_i_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
`ifdef REGBANK_SEQ_ROUND_ROBIN_EN
            rr_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            op_q      <= op_d;
            data_q    <= data_d;
            rem_q     <= rem_d;
            id_q      <= id_d;
            reg_e_q   <= reg_e_d;
            fun_sel_q <= fun_sel_d;
            reg_i_q   <= reg_i_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
`ifdef REGBANK_SEQ_ROUND_ROBIN_EN
            rr_q      <= rr_d;
`endif
        end
    end

    // Enables drop immediately with reset so an aborted command writes nothing more
    assign reg_e_c_o     = reset_i ? '0 : reg_e_q;
    assign reg_fun_sel_o = fun_sel_q;
    assign reg_i_o       = reg_i_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign done_id_o     = done_id_q;

endmodule

// File: tb/tb_regbank_op_sequencer.sv
// Testbench for regbank_op_sequencer (NREG=3 so that sel=3 is out of range).
// A behavioural register bank is driven by the DUT enables; its contents are
// compared against command-level arithmetic kept in exp_r.

module tb_regbank_op_sequencer;

    localparam int NREG = 3;
    localparam int SELW = 2;
    localparam int CNTW = 4;

    localparam logic [1:0] OP_DEC   = 2'b00;
    localparam logic [1:0] OP_INC   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef struct packed {
        logic [1:0]  sel;
        logic [1:0]  op;
        logic [3:0]  cnt;
        logic [15:0] data;
    } cmd_t;

    typedef struct {
        logic        v0;
        cmd_t        c0;
        logic        v1;
        cmd_t        c1;
        int          who;
        int          en;
        int          lat;
        logic [15:0] val;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            r0v, r0r, r1v, r1r;
    logic [1:0]      r0s, r0o, r1s, r1o;
    logic [3:0]      r0c, r1c;
    logic [15:0]     r0d, r1d;
    logic [NREG-1:0] rege;
    logic [1:0]      fsel;
    logic [15:0]     regi;
    logic            busy, done, did;

    int              n_cmp = 0;
    int              n_err = 0;
    int              prio  = 0;
    logic [15:0]     exp_r [NREG];
    logic [15:0]     bank  [NREG];
    logic            bank_clr;
    vec_t            tbl   [10];

    always #5 clk = ~clk;

    regbank_op_sequencer #(.NREG(NREG), .SELW(SELW), .CNTW(CNTW)) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .req0_valid_i  (r0v),
        .req0_ready_c_o(r0r),
        .req0_sel_i    (r0s),
        .req0_op_i     (r0o),
        .req0_count_i  (r0c),
        .req0_data_i   (r0d),
        .req1_valid_i  (r1v),
        .req1_ready_c_o(r1r),
        .req1_sel_i    (r1s),
        .req1_op_i     (r1o),
        .req1_count_i  (r1c),
        .req1_data_i   (r1d),
        .reg_e_c_o     (rege),
        .reg_fun_sel_o (fsel),
        .reg_i_o       (regi),
        .busy_o        (busy),
        .done_o        (done),
        .done_id_o     (did)
    );

    // Register bank: load/inc/dec/clear registers with modulo-2^16 behaviour
    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (bank_clr) begin
                bank[i] <= 16'h0;
            end else if (rege[i]) begin
                case (fsel)
                    2'b00:   bank[i] <= bank[i] - 16'd1;
                    2'b01:   bank[i] <= bank[i] + 16'd1;
                    2'b10:   bank[i] <= regi;
                    default: bank[i] <= 16'h0;
                endcase
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic cmd_t mkcmd(input logic [1:0] s, input logic [1:0] o,
                                   input logic [3:0] c, input logic [15:0] d);
        cmd_t r;
        r.sel = s; r.op = o; r.cnt = c; r.data = d;
        return r;
    endfunction

    // Command-level model
    function automatic int m_steps(input cmd_t c);
        return (c.op == OP_LOAD || c.op == OP_CLEAR) ? 1 : int'(c.cnt);
    endfunction

    function automatic int m_en(input cmd_t c);
        return (int'(c.sel) < NREG) ? m_steps(c) : 0;
    endfunction

    function automatic int m_lat(input cmd_t c);
        return m_steps(c) + 1;
    endfunction

    function automatic int m_winner(input logic v0, input logic v1);
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
`ifdef REGBANK_SEQ_ROUND_ROBIN_EN
        return prio;
`else
        return 0;
`endif
    endfunction

    task automatic m_apply(input cmd_t c);
        if (int'(c.sel) < NREG) begin
            case (c.op)
                OP_DEC:  exp_r[c.sel] = exp_r[c.sel] - 16'(c.cnt);
                OP_INC:  exp_r[c.sel] = exp_r[c.sel] + 16'(c.cnt);
                OP_LOAD: exp_r[c.sel] = c.data;
                default: exp_r[c.sel] = 16'h0;
            endcase
        end
    endtask

    task automatic set_req(input logic v0, input cmd_t c0, input logic v1, input cmd_t c1);
        r0v = v0; r0s = c0.sel; r0o = c0.op; r0c = c0.cnt; r0d = c0.data;
        r1v = v1; r1s = c1.sel; r1o = c1.op; r1c = c1.cnt; r1d = c1.data;
    endtask

    task automatic reset_dut();
        set_req(1'b0, mkcmd(2'd0, 2'd0, 4'd0, 16'h0), 1'b0, mkcmd(2'd0, 2'd0, 4'd0, 16'h0));
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        prio = 0;
    endtask

    task automatic check_bank(input string nm);
        for (int i = 0; i < NREG; i++) begin
            chk($sformatf("%s_bank%0d", nm, i), int'(bank[i]), int'(exp_r[i]));
        end
    endtask

    // Issue one command (DUT idle, called at posedge+1) and observe it to completion
    task automatic run_and_check(input string nm, input logic v0, input cmd_t c0,
                                 input logic v1, input cmd_t c1, input int e_who,
                                 input int e_en, input int e_lat, output int who);
        cmd_t            wc;
        cmd_t            we;
        int              en_n;
        int              lat;
        logic [NREG-1:0] en_v;
        logic [NREG-1:0] e_v;
        logic            bad;
        logic            got_id;
        who = -1; en_n = 0; lat = -1; en_v = '0; bad = 1'b0; got_id = 1'b0;
        set_req(v0, c0, v1, c1);
        for (int k = 0; k < 4 && who < 0; k++) begin
            @(negedge clk);
            if (r0r && r1r)  who = 2;
            else if (r0r)    who = 0;
            else if (r1r)    who = 1;
            @(posedge clk); #1;
        end
        set_req(1'b0, c0, 1'b0, c1);
        wc = (who == 1) ? c1 : c0;
        if (who >= 0) begin
            for (int k = 1; k <= 40 && lat < 0; k++) begin
                @(negedge clk);
                if (rege != '0) begin
                    en_n++;
                    en_v = en_v | rege;
                    if (fsel != wc.op || regi != wc.data) bad = 1'b1;
                end
                if (done) begin
                    lat = k;
                    got_id = did;
                end
                @(posedge clk); #1;
            end
        end
        we  = (e_who == 1) ? c1 : c0;
        e_v = '0;
        if (e_en > 0 && int'(we.sel) < NREG) e_v[we.sel] = 1'b1;
        chk({nm, "_who"},   who, e_who);
        chk({nm, "_nen"},   en_n, e_en);
        chk({nm, "_lat"},   lat, e_lat);
        chk({nm, "_id"},    int'(got_id), e_who);
        chk({nm, "_rege"},  int'(en_v), int'(e_v));
        chk({nm, "_fs_ri"}, int'(bad), 0);
        chk({nm, "_busy"},  int'(busy), 0);
        m_apply(we);
        prio = (e_who == 0) ? 1 : 0;
    endtask

    initial begin
        int   who;
        int   last_t;
        int   g;
        int   n1;
        int   exp_n1;
        logic got;
        logic sd;
        logic se;
        cmd_t nc;

        nc = mkcmd(2'd0, 2'd0, 4'd0, 16'h0);
        for (int i = 0; i < NREG; i++) exp_r[i] = 16'h0;

        //             v0    c0                                          v1    c1                                   who en lat val
        tbl[0] = '{1'b1, mkcmd(2'd2, OP_LOAD,  4'd0,  16'h1234), 1'b0, nc,                                        0,  1,  2, 16'h1234};
        tbl[1] = '{1'b0, nc,                                       1'b1, mkcmd(2'd1, OP_LOAD, 4'd0, 16'hFFFE),   1,  1,  2, 16'hFFFE};
        tbl[2] = '{1'b0, nc,                                       1'b1, mkcmd(2'd1, OP_INC,  4'd3, 16'h0),      1,  3,  4, 16'h0001};
        tbl[3] = '{1'b1, mkcmd(2'd2, OP_DEC,   4'd0,  16'h0),    1'b0, nc,                                        0,  0,  1, 16'h1234};
        tbl[4] = '{1'b1, mkcmd(2'd3, OP_LOAD,  4'd0,  16'hBEEF), 1'b0, nc,                                        0,  0,  2, 16'h0};
        tbl[5] = '{1'b1, mkcmd(2'd2, OP_CLEAR, 4'd0,  16'h7777), 1'b0, nc,                                        0,  1,  2, 16'h0};
        tbl[6] = '{1'b0, nc,                                       1'b1, mkcmd(2'd0, OP_DEC,  4'd1, 16'h0),      1,  1,  2, 16'hFFFF};
        tbl[7] = '{1'b1, mkcmd(2'd0, OP_INC,   4'd15, 16'h0),    1'b0, nc,                                        0, 15, 16, 16'h000E};
`ifdef REGBANK_SEQ_ROUND_ROBIN_EN
        tbl[8] = '{1'b1, mkcmd(2'd0, OP_LOAD,  4'd0,  16'hAAAA), 1'b1, mkcmd(2'd1, OP_LOAD, 4'd0, 16'h5555),   1,  1,  2, 16'h5555};
`else
        tbl[8] = '{1'b1, mkcmd(2'd0, OP_LOAD,  4'd0,  16'hAAAA), 1'b1, mkcmd(2'd1, OP_LOAD, 4'd0, 16'h5555),   0,  1,  2, 16'hAAAA};
`endif
        tbl[9] = '{1'b1, mkcmd(2'd0, OP_LOAD,  4'd0,  16'hAAAA), 1'b1, mkcmd(2'd1, OP_LOAD, 4'd0, 16'h5555),   0,  1,  2, 16'hAAAA};

        // Reset values
        set_req(1'b0, nc, 1'b0, nc);
        rst = 1'b1;
        bank_clr = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rst_rege",   int'(rege), 0);
        chk("rst_busy",   int'(busy), 0);
        chk("rst_done",   int'(done), 0);
        chk("rst_doneid", int'(did),  0);
        chk("rst_funsel", int'(fsel), 0);
        chk("rst_regi",   int'(regi), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bank_clr = 1'b0;
        @(negedge clk);
        chk("idle_busy",   int'(busy), 0);
        chk("idle_ready0", int'(r0r),  0);
        chk("idle_ready1", int'(r1r),  0);
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            cmd_t we;
            run_and_check($sformatf("vec%0d", i), tbl[i].v0, tbl[i].c0, tbl[i].v1, tbl[i].c1,
                          tbl[i].who, tbl[i].en, tbl[i].lat, who);
            we = (tbl[i].who == 1) ? tbl[i].c1 : tbl[i].c0;
            if (int'(we.sel) < NREG) begin
                chk($sformatf("vec%0d_val", i), int'(bank[we.sel]), int'(tbl[i].val));
            end
            check_bank($sformatf("vec%0d", i));
        end

        // Reset on the 4th EXEC cycle of a 15-step INC aborts the command
        reset_dut();
        run_and_check("pre", 1'b1, mkcmd(2'd0, OP_LOAD, 4'd0, 16'h0100), 1'b0, nc, 0, 1, 2, who);
        set_req(1'b0, nc, 1'b1, mkcmd(2'd0, OP_INC, 4'd15, 16'h0));
        got = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(negedge clk);
            got = r1r;
            @(posedge clk); #1;
        end
        chk("abort_hs", int'(got), 1);
        set_req(1'b0, nc, 1'b0, nc);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rege_forced", int'(rege), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        sd = 1'b0; se = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (done) sd = 1'b1;
            if (rege != '0) se = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_done", int'(sd), 0);
        chk("abort_no_en",   int'(se), 0);
        @(posedge clk); #1;
        exp_r[0] = 16'h0103;
        prio = 0;
        check_bank("abort");
        run_and_check("post_abort", 1'b0, nc, 1'b1, mkcmd(2'd0, OP_LOAD, 4'd0, 16'h4242), 1, 1, 2, who);
        check_bank("post_abort");

        // Both requesters valid back-to-back with CLEAR commands
        reset_dut();
        run_and_check("seed0", 1'b1, mkcmd(2'd0, OP_LOAD, 4'd0, 16'h1111), 1'b0, nc, 0, 1, 2, who);
        run_and_check("seed1", 1'b0, nc, 1'b1, mkcmd(2'd1, OP_LOAD, 4'd0, 16'h2222), 1, 1, 2, who);
        reset_dut();
        set_req(1'b1, mkcmd(2'd0, OP_CLEAR, 4'd0, 16'h0), 1'b1, mkcmd(2'd1, OP_CLEAR, 4'd0, 16'h0));
        last_t = -1; g = 0; n1 = 0;
        for (int cyc = 0; cyc < 40 && g < 6; cyc++) begin
            @(negedge clk);
            if (r0r || r1r) begin
                who = (r0r && r1r) ? 2 : (r1r ? 1 : 0);
                chk($sformatf("arb_who%0d", g), who, m_winner(1'b1, 1'b1));
                if (last_t >= 0) chk($sformatf("arb_gap%0d", g), cyc - last_t, 3);
                m_apply(mkcmd((who == 1) ? 2'd1 : 2'd0, OP_CLEAR, 4'd0, 16'h0));
                prio = (who == 0) ? 1 : 0;
                if (who == 1) n1++;
                last_t = cyc;
                g++;
            end
            @(posedge clk); #1;
        end
        set_req(1'b0, nc, 1'b0, nc);
        chk("arb_grants", g, 6);
`ifdef REGBANK_SEQ_ROUND_ROBIN_EN
        exp_n1 = 3;
`else
        exp_n1 = 0;
`endif
        chk("arb_req1_grants", n1, exp_n1);
        for (int k = 0; k < 20 && busy; k++) @(negedge clk);
        chk("arb_idle", int'(busy), 0);
        @(posedge clk); #1;
        check_bank("arb");

        // Randomized commands against the command-level model
        for (int t = 0; t < 40; t++) begin
            logic v0;
            logic v1;
            cmd_t c0;
            cmd_t c1;
            cmd_t wm;
            int   ew;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v1 = 1'b1;
            c0 = mkcmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       4'($urandom_range(0, 15)), 16'($urandom));
            c1 = mkcmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       4'($urandom_range(0, 15)), 16'($urandom));
            ew = m_winner(v0, v1);
            wm = (ew == 1) ? c1 : c0;
            run_and_check($sformatf("rnd%0d", t), v0, c0, v1, c1, ew, m_en(wm), m_lat(wm), who);
            check_bank($sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regbank_op_sequencer.md
Name: regbank_op_sequencer

Overview:
- Controller for a bank of NREG 16-bit registers of the load/inc/dec/clear type: per-register enable, shared 2-bit FunSel, shared 16-bit data input.
- Arbitrates between two requesters (e.g. datapath writeback and address unit) and accepts one command at a time.
- Turns multi-step INC/DEC commands into a sequence of single-step register operations, then signals completion.

Parameters:
- NREG, 4, number of registers driven (RegE width)
- SELW, 2, register-select width; must satisfy 2**SELW >= NREG
- CNTW, 4, step-count width for INC/DEC commands

Ports:
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- Req0Valid  in  1  requester 0 command valid
- Req0Ready  out  1  requester 0 command accepted this cycle
- Req0Sel  in  SELW  target register index
- Req0Op  in  2  00 DEC, 01 INC, 10 LOAD, 11 CLEAR (same encoding as register FunSel)
- Req0Count  in  CNTW  step count for INC/DEC; ignored for LOAD/CLEAR
- Req0Data  in  16  load value for LOAD
- Req1Valid, Req1Ready, Req1Sel, Req1Op, Req1Count, Req1Data  same as requester 0, for requester 1
- RegE  out  NREG  one-hot register enable
- RegFunSel  out  2  function select to all registers
- RegI  out  16  data to all registers
- Busy  out  1  command in progress (state != IDLE)
- Done  out  1  one-cycle completion pulse
- DoneId  out  1  requester id of the completed command; valid while Done=1

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high.
- States: IDLE, EXEC, DONE.
- Reset values: state IDLE, RegE=0, RegFunSel=00, RegI=0, Busy=0, Done=0, DoneId=0, rr pointer=0 (requester 0 favoured).
- While Reset=1, RegE is forced to 0 combinationally. Reset during EXEC aborts the command: no further register enables, no Done.
- IDLE:
  - ReqNReady = grant to N. Ready is asserted only in IDLE. Ready depends on Valid; Valid does not depend on Ready.
  - Arbitration: a single valid requester wins. If both are valid, the rr-pointer requester wins.
  - On handshake (Valid & Ready): latch sel, op, count, data and winner id. rr pointer <= ~winner.
  - LOAD/CLEAR, or INC/DEC with count != 0, -> EXEC.
  - INC/DEC with count == 0 -> DONE directly (no-op, RegE stays 0).
- EXEC:
  - RegE = onehot(sel), RegFunSel = latched op, RegI = latched data.
  - Outputs are decoded from state registers only; there is no combinational path from ReqN inputs to Reg* outputs.
  - LOAD/CLEAR: exactly 1 EXEC cycle, then DONE.
  - INC/DEC: remaining counter starts at count and decrements each EXEC cycle. Leave for DONE when remaining == 1, giving exactly count enable cycles.
  - Maximum count = 2**CNTW-1.
  - Register wrap-around (0xFFFF+1, 0x0000-1) is the register's own modulo-2^16 behaviour; the controller does not detect it.
- DONE: Done=1, DoneId=latched id for one cycle, RegE=0, -> IDLE.
- Out-of-range sel (sel >= NREG): command is accepted and sequenced normally, RegE stays all-zero, Done still pulses.
- Throughput: LOAD/CLEAR takes 3 cycles from handshake to the next possible handshake (IDLE, EXEC, DONE). INC/DEC takes count+2 cycles.
- RegFunSel and RegI hold their last EXEC values outside EXEC; only RegE gates writes.

Optional Feature:
- Macro: REGBANK_SEQ_ROUND_ROBIN_EN
- Defined: round-robin arbitration as above.
- Undefined: fixed priority. Requester 0 always wins when both are valid; the rr pointer is not implemented.

Test Plan:
- Reset, then Req0 LOAD sel=2 data=0x1234 -> Req0Ready=1 for 1 cycle; next cycle RegE=0100, RegFunSel=10, RegI=0x1234; following cycle Done=1, DoneId=0; modelled R2=0x1234.
- R1=0xFFFE, Req1 INC sel=1 count=3 -> RegE=0010 for exactly 3 consecutive cycles with RegFunSel=01; R1 ends 0x0001 (wraps); Done 1 cycle later, DoneId=1.
- Req0 and Req1 both valid continuously with CLEAR commands (define set) -> grants alternate 0,1,0,1; without the macro -> requester 0 granted every time, requester 1 never.
- Req0 DEC count=0 -> handshake, next cycle Done=1, RegE=0 throughout; register value unchanged.
- Req1 INC sel=0 count=15, Reset asserted on 4th EXEC cycle -> R0 incremented exactly 3 times (4th suppressed), no Done, Busy=0 after the reset edge, next command accepted normally.
- Req0 LOAD sel=3 (NREG=3 build) data=0xBEEF -> RegE stays 0, no register changes, Done pulses 2 cycles after handshake.
